// File: rtl/pll_mdrp_responder.sv
// MDRP responder: decodes the sequencer's opcode/address-increment/write-data
// stream into a shadow register bank, returns registered read data, and
// emulates PLL relock timing with a lock-delay counter.
module pll_mdrp_responder #(
    parameter int unsigned NREGS       = 16,
    parameter int unsigned LOCK_CYCLES = 64,
    parameter logic [7:0]  MULT_RST    = 8'd10,
    parameter logic [7:0]  DIV_RST     = 8'd1,
    parameter logic [7:0]  ODIV_RST    = 8'd4
) (
    input  logic       mdclk,
    input  logic       resetn,
    input  logic       pll_rst,
    input  logic [1:0] mdopc,
    input  logic       mdainc,
    input  logic [7:0] mdwdi,
    output logic [7:0] mdrdo,
    output logic       lock,
    output logic [7:0] cfg_mult,
    output logic [7:0] cfg_div,
    output logic [7:0] cfg_odiv,
    output logic       cfg_dirty
);

    localparam int unsigned   CntW    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(LOCK_CYCLES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [1:0] OpNop     = 2'b00;
    localparam logic [1:0] OpWrite   = 2'b01;
    localparam logic [1:0] OpRead    = 2'b10;
    localparam logic [1:0] OpSetAddr = 2'b11;

    typedef enum logic [1:0] {
        StHeld,
        StLocking,
        StLocked
    } lock_state_e;

    // Reset value of each shadow register; only the frequency registers are non-zero.
    function automatic logic [7:0] reg_rst(input int unsigned idx);
        logic [7:0] val;
        case (idx)
            0:       val = MULT_RST;
            1:       val = DIV_RST;
            2:       val = ODIV_RST;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    logic [7:0]      regs_q [NREGS];
    logic [7:0]      regs_d [NREGS];
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      mdrdo_q, mdrdo_d;
    logic            dirty_q, dirty_d;
    logic [7:0]      rd_data;
    lock_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Read mux; unimplemented addresses fall through to zero.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (addr_q == 8'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    // Command decode: register bank, address pointer, read data and dirty flag.
    always_comb begin
        regs_d  = regs_q;
        addr_d  = addr_q;
        mdrdo_d = mdrdo_q;
        dirty_d = dirty_q;
        case (mdopc)
            OpWrite: begin
                // Writes beyond NREGS match no entry and are dropped.
                for (int i = 0; i < NREGS; i++) begin
                    if (addr_q == 8'(i)) begin
                        regs_d[i] = mdwdi;
                    end
                end
                if (addr_q <= 8'd2) begin
                    dirty_d = 1'b1;
                end
            end
            OpRead:    mdrdo_d = rd_data;
            OpSetAddr: addr_d  = mdwdi;
            OpNop:     ;
            default:   ;
        endcase
        // Post-increment after the access; 8-bit arithmetic wraps FF to 00.
        if (mdainc && (mdopc != OpSetAddr)) begin
            addr_d = addr_q + 8'd1;
        end
        // PLL reset clears dirty even when a frequency write lands this cycle.
        if (pll_rst) begin
            dirty_d = 1'b0;
        end
    end

    // Datapath state registers.
    always_ff @(posedge mdclk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= reg_rst(i);
            end
            addr_q  <= 8'h00;
            mdrdo_q <= 8'h00;
            dirty_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            addr_q  <= addr_d;
            mdrdo_q <= mdrdo_d;
            dirty_q <= dirty_d;
        end
    end

    // Lock FSM state and delay counter; reset starts directly in LOCKING.
    always_ff @(posedge mdclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StLocking;
            cnt_q   <= CntInit;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lock FSM next state: pll_rst wins from any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pll_rst) begin
            state_d = StHeld;
            cnt_d   = CntInit;
        end else begin
            case (state_q)
                StHeld: begin
                    state_d = StLocking;
                    cnt_d   = CntInit;
                end
                StLocking: begin
                    cnt_d = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_d = StLocked;
                    end
                end
                StLocked: ;
                default: begin
                    state_d = StHeld;
                    cnt_d   = CntInit;
                end
            endcase
        end
    end

    // Lock FSM output: decoded straight from the state flops.
    always_comb begin
        lock = (state_q == StLocked);
    end

    assign mdrdo     = mdrdo_q;
    assign cfg_dirty = dirty_q;
    assign cfg_mult  = regs_q[0];
    assign cfg_div   = regs_q[1];

    // With only two registers the output divider is not writable.
    if (NREGS > 2) begin : g_odiv_reg
        assign cfg_odiv = regs_q[2];
    end else begin : g_odiv_const
        assign cfg_odiv = ODIV_RST;
    end

endmodule

// File: tb/tb_pll_mdrp_responder.sv
// Self-checking bench for pll_mdrp_responder: READ expectations go through a
// scoreboard queue, other checks are inline per scenario task.
module tb_pll_mdrp_responder;

    localparam int LOCK = 64;
    localparam int NR   = 16;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] WRITE = 2'b01;
    localparam logic [1:0] READ  = 2'b10;
    localparam logic [1:0] SETA  = 2'b11;

    logic       mdclk = 1'b0;
    logic       resetn = 1'b1;
    logic       pll_rst = 1'b0;
    logic [1:0] mdopc = 2'b00;
    logic       mdainc = 1'b0;
    logic [7:0] mdwdi = 8'h00;
    logic [7:0] mdrdo;
    logic       lock;
    logic [7:0] cfg_mult;
    logic [7:0] cfg_div;
    logic [7:0] cfg_odiv;
    logic       cfg_dirty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] m_regs [NR];
    logic [7:0] m_addr;

    pll_mdrp_responder #(
        .NREGS      (NR),
        .LOCK_CYCLES(LOCK),
        .MULT_RST   (8'd10),
        .DIV_RST    (8'd1),
        .ODIV_RST   (8'd4)
    ) dut (
        .mdclk    (mdclk),
        .resetn   (resetn),
        .pll_rst  (pll_rst),
        .mdopc    (mdopc),
        .mdainc   (mdainc),
        .mdwdi    (mdwdi),
        .mdrdo    (mdrdo),
        .lock     (lock),
        .cfg_mult (cfg_mult),
        .cfg_div  (cfg_div),
        .cfg_odiv (cfg_odiv),
        .cfg_dirty(cfg_dirty)
    );

    always #5 mdclk = ~mdclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_regs[0] = 8'd10;
        m_regs[1] = 8'd1;
        m_regs[2] = 8'd4;
        m_addr    = 8'h00;
        exp_q.delete();
    endtask

    // Drive one command from a negedge, clock it, and score any READ result.
    task automatic cmd(input logic [1:0] opc, input logic ainc, input logic [7:0] wd,
                       input logic prst);
        logic [7:0] e;
        mdopc   = opc;
        mdainc  = ainc;
        mdwdi   = wd;
        pll_rst = prst;
        case (opc)
            WRITE: if (m_addr < NR) m_regs[m_addr[3:0]] = wd;
            READ:  exp_q.push_back((m_addr < NR) ? m_regs[m_addr[3:0]] : 8'h00);
            SETA:  m_addr = wd;
            default: ;
        endcase
        if (opc != SETA && ainc) m_addr = m_addr + 8'd1;
        @(posedge mdclk);
        @(negedge mdclk);
        if (opc == READ) begin
            e = exp_q.pop_front();
            n_checks++;
            if (mdrdo !== e) begin
                n_fail++;
                $display("FAIL read_data: got %h expected %h", mdrdo, e);
            end
        end
        mdopc   = NOP;
        mdainc  = 1'b0;
        pll_rst = 1'b0;
    endtask

    // Count edges (from a negedge) until lock rises, bounded.
    task automatic count_to_lock(input string name, input int expected);
        int n;
        n = 0;
        while (lock !== 1'b1 && n < 300) begin
            @(posedge mdclk);
            n++;
            @(negedge mdclk);
        end
        n_checks++;
        if (n != expected) begin
            n_fail++;
            $display("FAIL %s: lock after %0d edges, expected %0d", name, n, expected);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        @(posedge mdclk);
        @(negedge mdclk);
        check8("rst_mult", cfg_mult, 8'd10);
        check8("rst_div", cfg_div, 8'd1);
        check8("rst_odiv", cfg_odiv, 8'd4);
        check8("rst_mdrdo", mdrdo, 8'h00);
        check1("rst_dirty", cfg_dirty, 1'b0);
        check1("rst_lock", lock, 1'b0);
        model_reset();
        resetn = 1'b1;
        count_to_lock("rst_lock_delay", LOCK);
        check8("rst_mdrdo_after", mdrdo, 8'h00);
    endtask

    task automatic test_write_read();
        cmd(SETA, 1'b0, 8'h00, 1'b0);
        cmd(WRITE, 1'b1, 8'h14, 1'b0);
        cmd(WRITE, 1'b1, 8'h02, 1'b0);
        cmd(WRITE, 1'b0, 8'h08, 1'b0);
        check8("wr_mult", cfg_mult, 8'h14);
        check8("wr_div", cfg_div, 8'h02);
        check8("wr_odiv", cfg_odiv, 8'h08);
        check1("wr_dirty", cfg_dirty, 1'b1);
        cmd(SETA, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cmd(READ, 1'b1, 8'h00, 1'b0);
        cmd(NOP, 1'b0, 8'h00, 1'b0);
        check8("rd_hold", mdrdo, 8'h08);
    endtask

    task automatic test_back_to_back();
        cmd(SETA, 1'b0, 8'h05, 1'b0);
        cmd(WRITE, 1'b0, 8'h5A, 1'b0);
        cmd(READ, 1'b0, 8'h00, 1'b0);
        cmd(SETA, 1'b0, 8'h0F, 1'b0);
        cmd(READ, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_oor_wrap();
        cmd(SETA, 1'b0, 8'hFF, 1'b0);
        cmd(WRITE, 1'b1, 8'hAA, 1'b0);
        cmd(READ, 1'b0, 8'h00, 1'b0);
        check8("oor_mult", cfg_mult, 8'h14);
        cmd(SETA, 1'b0, 8'hFF, 1'b0);
        cmd(READ, 1'b0, 8'h00, 1'b0);
        cmd(SETA, 1'b0, 8'h10, 1'b0);
        cmd(WRITE, 1'b0, 8'h77, 1'b0);
        cmd(READ, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_relock();
        check1("relock_pre", lock, 1'b1);
        cmd(SETA, 1'b0, 8'h00, 1'b0);
        cmd(WRITE, 1'b0, 8'h20, 1'b0);
        check1("relock_wr_lock", lock, 1'b1);
        check8("relock_wr_mult", cfg_mult, 8'h20);
        cmd(NOP, 1'b0, 8'h00, 1'b1);
        check1("relock_fall", lock, 1'b0);
        check1("relock_dirty", cfg_dirty, 1'b0);
        cmd(NOP, 1'b0, 8'h00, 1'b1);
        cmd(NOP, 1'b0, 8'h00, 1'b1);
        count_to_lock("relock_delay", LOCK + 1);
    endtask

    task automatic test_simultaneous();
        cmd(SETA, 1'b0, 8'h00, 1'b0);
        cmd(WRITE, 1'b0, 8'h14, 1'b0);
        check1("sim_dirty_pre", cfg_dirty, 1'b1);
        cmd(SETA, 1'b0, 8'h01, 1'b0);
        cmd(WRITE, 1'b0, 8'h33, 1'b1);
        check8("sim_div", cfg_div, 8'h33);
        check1("sim_dirty", cfg_dirty, 1'b0);
        check1("sim_lock", lock, 1'b0);
        count_to_lock("sim_relock", LOCK + 1);
        cmd(READ, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_midlock();
        cmd(SETA, 1'b0, 8'h02, 1'b0);
        cmd(WRITE, 1'b0, 8'h09, 1'b0);
        check1("mid_dirty_pre", cfg_dirty, 1'b1);
        cmd(NOP, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) cmd(NOP, 1'b0, 8'h00, 1'b0);
        mdopc = WRITE;
        mdwdi = 8'h55;
        #2 resetn = 1'b0;
        #1;
        check8("mid_mult", cfg_mult, 8'd10);
        check8("mid_div", cfg_div, 8'd1);
        check8("mid_odiv", cfg_odiv, 8'd4);
        check8("mid_mdrdo", mdrdo, 8'h00);
        check1("mid_dirty", cfg_dirty, 1'b0);
        check1("mid_lock", lock, 1'b0);
        @(posedge mdclk);
        @(negedge mdclk);
        check8("mid_odiv_held", cfg_odiv, 8'd4);
        mdopc = NOP;
        mdwdi = 8'h00;
        model_reset();
        resetn = 1'b1;
        count_to_lock("mid_lock_delay", LOCK);
        cmd(SETA, 1'b0, 8'h02, 1'b0);
        cmd(READ, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_oor_wrap();
        test_relock();
        test_simultaneous();
        test_reset_midlock();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
